// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, drives a combinational instruction ROM and
// buffers {pc, inst} pairs for decode. Optional zero-word halt: FETCH_ZERO_HALT_EN.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_ce,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        halted
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;

    state_t         state_reg, state_next;
    logic [31:0]    pc_reg, pc_next;
    logic [CW-1:0]  count_reg;
    logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [31:0]    pc_mem   [DEPTH];
    logic [31:0]    inst_mem [DEPTH];
    logic           fetch, push, pop, has_data, halt_hit;
    logic           unused_bits;

    assign unused_bits = ^redirect_pc[1:0];

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + AW'(1);
    endfunction

    // Head is only meaningful while the buffer holds data; otherwise read as zero.
    assign has_data  = rst && (count_reg != '0);
    assign out_valid = has_data && !redirect;
    assign pop       = out_valid && out_ready;
    assign out_pc    = has_data ? pc_mem[rd_ptr_reg]   : '0;
    assign out_inst  = has_data ? inst_mem[rd_ptr_reg] : '0;
    assign mem_ce    = fetch;
    assign mem_addr  = pc_reg;

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        fetch      = 1'b0;
        push       = 1'b0;
        halt_hit   = 1'b0;
        case (state_reg)
            IDLE: state_next = FETCH;
            FETCH: begin
                // A pop in this cycle frees a slot for the word being fetched now.
                fetch = rst && !redirect && ((count_reg < DEPTH_C) || pop);
`ifdef FETCH_ZERO_HALT_EN
                if (fetch && (mem_inst == 32'h0000_0000)) begin
                    halt_hit   = 1'b1;
                    state_next = HALTED;
                end else begin
                    push = fetch;
                end
`else
                push = fetch;
`endif
                if (push) begin
                    pc_next = pc_reg + 32'd4;
                end
            end
            default: ;
        endcase
        if (redirect) begin
            state_next = FETCH;
            pc_next    = {redirect_pc[31:2], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= IDLE;
            pc_reg     <= RESET_PC;
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            if (redirect) begin
                count_reg  <= '0;
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (push) begin
                    pc_mem[wr_ptr_reg]   <= pc_reg;
                    inst_mem[wr_ptr_reg] <= mem_inst;
                    wr_ptr_reg           <= ptr_inc(wr_ptr_reg);
                end
                if (pop) begin
                    rd_ptr_reg <= ptr_inc(rd_ptr_reg);
                end
                case ({push, pop})
                    2'b10:   count_reg <= count_reg + CW'(1);
                    2'b01:   count_reg <= count_reg - CW'(1);
                    default: ;
                endcase
            end
        end
    end

`ifdef FETCH_ZERO_HALT_EN
    logic halted_reg;
    always_ff @(posedge clk) begin
        if (!rst || redirect) begin
            halted_reg <= 1'b0;
        end else if (halt_hit) begin
            halted_reg <= 1'b1;
        end
    end
    assign halted = halted_reg;
`else
    logic unused_halt;
    assign unused_halt = halt_hit;
    assign halted = 1'b0;
`endif

endmodule
